// File: rtl/cond_flags.sv
// cond_flags: LC-3 condition-code unit with a flag save/restore stack.
//
// Derives one-hot N/Z/P from a WIDTH-bit bus, accepts a direct NZP load
// (PSR writes), saves/restores flag sets on a DEPTH-entry hardware stack
// (interrupt entry / RTI) and evaluates the BR nzp condition.
//
// Ports:
//   clk       system clock, all state updates on rising edge
//   rst_n     synchronous active-low reset
//   flag_we   update flags from classify(Buss)
//   Buss      WIDTH-bit value to classify
//   ld_nzp    load flags directly from nzp_in (not checked for one-hot)
//   nzp_in    direct flag value {N,Z,P}
//   push      save current flags onto the stack
//   pop       restore flags from the stack top
//   err_clr   clear sticky err
//   cc        branch condition field {n,z,p}
//   N, Z, P   registered flags
//   br_taken  |(cc & {N,Z,P}), combinational
//   depth     number of valid stack entries
//   empty     depth == 0
//   full      depth == DEPTH
//   err       sticky overflow / underflow / push-pop conflict
module cond_flags #(
    parameter int          WIDTH   = 16,
    parameter int          DEPTH   = 4,
    parameter logic [2:0]  RST_NZP = 3'b010
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flag_we,
    input  logic [WIDTH-1:0]           Buss,
    input  logic                       ld_nzp,
    input  logic [2:0]                 nzp_in,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    input  logic [2:0]                 cc,
    output logic                       N,
    output logic                       Z,
    output logic                       P,
    output logic                       br_taken,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       err
);

    localparam int DW = $clog2(DEPTH + 1);

    logic [2:0]    r_nzp;
    logic [DW-1:0] r_depth;
    logic          r_err;
    logic [2:0]    r_stack [DEPTH];

    logic [2:0]    w_class;
    logic [2:0]    w_top;
    logic [2:0]    w_nzp_next;
    logic          w_empty;
    logic          w_full;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_err_ev;

    assign w_empty = (r_depth == '0);
    assign w_full  = (r_depth == DW'(DEPTH));

    // push and pop together cancel each other; each alone is valid only
    // when the stack has room / has an entry.
    assign w_push_ok = push & ~pop & ~w_full;
    assign w_pop_ok  = pop & ~push & ~w_empty;
    assign w_err_ev  = (push & pop) | (push & ~pop & w_full) | (pop & ~push & w_empty);

    always_comb begin
        w_class = 3'b001;
        if (Buss[WIDTH-1]) begin
            w_class = 3'b100;
        end else if (Buss == '0) begin
            w_class = 3'b010;
        end
    end

    // Stack top is entry[depth-1]; a compare loop avoids an index whose
    // width differs from the array address width.
    always_comb begin
        w_top = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_depth == DW'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    always_comb begin
        w_nzp_next = r_nzp;
        if (w_pop_ok) begin
            w_nzp_next = w_top;
        end else if (ld_nzp) begin
            w_nzp_next = nzp_in;
        end else if (flag_we) begin
            w_nzp_next = w_class;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nzp   <= RST_NZP;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_nzp <= w_nzp_next;
            if (w_push_ok) begin
                r_depth <= r_depth + DW'(1);
            end else if (w_pop_ok) begin
                r_depth <= r_depth - DW'(1);
            end
            if (w_err_ev) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Stack contents are not reset; the pre-edge flags are saved so a
    // simultaneous flag update does not leak into the saved copy.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rst_n && w_push_ok && (r_depth == DW'(i))) begin
                r_stack[i] <= r_nzp;
            end
        end
    end

    assign N        = r_nzp[2];
    assign Z        = r_nzp[1];
    assign P        = r_nzp[0];
    assign br_taken = |(cc & r_nzp);
    assign depth    = r_depth;
    assign empty    = w_empty;
    assign full     = w_full;
    assign err      = r_err;

endmodule

// File: doc/cond_flags.md
# cond_flags

Parametrised condition-code unit for the LC-3 datapath. It is the successor to the fixed 16-bit NZP register. It derives the N/Z/P flags from a bus of configurable width and also accepts a direct NZP load for PSR writes. It keeps a hardware save/restore stack of flag sets for interrupt entry and RTI, and it evaluates the branch condition (BR nzp field) against the current flags.

## Interface
- WIDTH, 16, width of the bus the flags are derived from (≥2)
- DEPTH, 4, number of flag sets the save stack holds (≥1)
- RST_NZP, 3'b010, flag value loaded on reset, as {N,Z,P}
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- flag_we  in  1  update flags from Buss
- Buss  in  WIDTH  value to classify
- ld_nzp  in  1  load flags directly from nzp_in
- nzp_in  in  3  direct flag value {N,Z,P}
- push  in  1  save current flags onto the stack (interrupt entry)
- pop  in  1  restore flags from the stack top (RTI)
- err_clr  in  1  clear the sticky err flag
- cc  in  3  branch condition field {n,z,p}
- N, Z, P  out  1 each  current flags (registered)
- br_taken  out  1  |(cc & {N,Z,P}); combinational from the registered flags
- depth  out  $clog2(DEPTH+1)  number of valid stack entries
- empty, full  out  1  depth==0, depth==DEPTH
- err  out  1  sticky overflow/underflow/conflict indicator

## Operation
- Classify Buss as follows:
  - N=Buss[WIDTH-1].
  - Otherwise Z=(Buss==0).
  - Otherwise P=1.
  - The result is always one-hot.
- Flag register next-value priority, from highest to lowest:
  - Valid pop: flags ← stack top.
  - ld_nzp: flags ← nzp_in, stored as given and not checked for one-hot.
  - flag_we: flags ← classify(Buss).
  - Otherwise: hold.
- When a valid pop occurs, any ld_nzp or flag_we in the same cycle is ignored.
- Push:
  - A push stores the current registered flags, i.e. the pre-edge value, into entry[depth], and depth increments.
  - A simultaneous flag_we or ld_nzp still updates the flags. The saved copy is the old value.
- Pop:
  - A pop returns entry[depth-1], and depth decrements.
- Push while full:
  - The stack is unchanged and err is set.
  - The flag update from ld_nzp/flag_we still applies.
- Pop while empty:
  - This is not a valid pop. Flags are not restored, and err is set.
  - ld_nzp/flag_we still apply at normal priority.
- push and pop asserted in the same cycle:
  - Neither takes effect: the stack is unchanged and there is no restore. err is set.
  - ld_nzp/flag_we still apply.
- err:
  - Set by any of the three error cases above.
  - Cleared by err_clr when no error occurs in the same cycle. If an error occurs in the same cycle as err_clr, the set wins.
- Stack storage is DEPTH×3 bits, indexed by depth. Entries at or above depth are don't-care and are not cleared by pop.

## Timing
- Reset (rst_n=0 at the edge):
  - {N,Z,P}=RST_NZP, depth=0, empty=1, full=0, err=0.
  - Stack contents are not reset.
  - Reset overrides every other input in that cycle, including mid-sequence push/pop.
- The flags, depth, empty, full and err outputs change only at the rising clock edge. Each has 1-cycle latency from its input strobe.
- br_taken has zero latency relative to cc. It reflects the flags as of the last edge.
- Back-to-back push/pop on consecutive cycles is supported at full rate. There are no bubbles or handshake.
- A push on cycle t followed by a pop on cycle t+1 restores exactly the flags present before edge t.

## Test plan
- Reset and classification (WIDTH=16):
  - Reset → NZP=010, depth=0, empty=1.
  - flag_we with Buss=16'h8000 → 100.
  - Buss=16'h0000 → 010.
  - Buss=16'h7FFF → 001.
  - Buss=16'h0001 → 001.
- Branch evaluation:
  - With NZP=100: cc=100 → br_taken=1; cc=011 → 0; cc=111 → 1.
  - With NZP=000 (via ld_nzp=000): cc=111 → 0.
- Interrupt nesting (DEPTH=4):
  - Set NZP=001, then push together with flag_we Buss=16'hFFFF → NZP=100, depth=1.
  - Push again → depth=2.
  - ld_nzp 010, then pop → NZP=100.
  - Pop → NZP=001, depth=0, empty=1, err=0.
- Overflow/underflow:
  - 5 pushes → depth=4, full=1, err=1 after the 5th.
  - err_clr → err=0.
  - 5 pops → depth=0 after the 4th. The 5th pop leaves the flags unchanged and sets err=1.
- Priority and conflict:
  - With depth=1 and top=010: pop + ld_nzp=100 + flag_we → NZP=010.
  - push+pop in the same cycle with depth=2 → depth stays 2, flags unchanged, err=1.
- Reset mid-operation:
  - With depth=3 and err=1: assert rst_n=0 together with push → depth=0, err=0, NZP=RST_NZP.
  - A subsequent pop → err=1, flags unchanged.
